// File: rtl/smp_mem_pkg.sv
// -----------------------------------------------------------------------------
// smp_mem_pkg
//   Shared definitions for the SMP burst memory:
//     - state_e      : burst controller states
//     - DEF_*        : default geometry (word, address and burst-length widths)
//     - even_parity  : even-parity helper used by the optional parity store
//   Optional feature macro used by the design: SMP_MEM_PARITY_EN
// -----------------------------------------------------------------------------
package smp_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_BEAT = 2'd2,
        WR_BEAT = 2'd3
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_BL_W   = 4;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves their parity unchanged.
    localparam int PAR_MAX_W  = 64;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/smp_ram_array.sv
// -----------------------------------------------------------------------------
// smp_ram_array
//   DEPTH x WORD_W single-clock RAM: one synchronous write port and one
//   registered read port (read data appears after the edge that samples
//   rd_addr). No reset on contents.
//   The INIT_FILE image is handed to the vendor RAM inference through the
//   ram_init_file attribute on the storage array.
// Ports
//   clk        in   1       clock
//   wr_en      in   1       write strobe
//   wr_addr    in   ADDR_W  write address
//   wr_word    in   WORD_W  write data
//   rd_addr    in   ADDR_W  read address, sampled every edge
//   rd_word_q  out  WORD_W  registered read data
// -----------------------------------------------------------------------------
module smp_ram_array #(
    parameter int    WORD_W    = 8,
    parameter int    ADDR_W    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_word_q
);

    localparam int DEPTH = 1 << ADDR_W;

    (* ram_init_file = INIT_FILE *)
    logic [WORD_W-1:0] mem_q [DEPTH];

    // The image file is consumed by the RAM inference flow via the attribute
    // above; nothing further is elaborated here.
    if (INIT_FILE != "") begin : g_init_image
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_word;
        end
        rd_word_q <= mem_q[rd_addr];
    end

endmodule

// File: rtl/smp_burst_memory.sv
// -----------------------------------------------------------------------------
// smp_burst_memory
//   Single-port burst RAM on the shared SMP tri-state data bus. Multi-beat
//   bursts with auto-incrementing (wrapping) addresses, registered read path
//   with RD_LAT cycles to the first beat, per-beat ack and busy handshake.
//   Optional macro: SMP_MEM_PARITY_EN -- stores an even-parity bit per word
//   and flags parity_err on a read beat whose stored bit disagrees.
// Ports
//   clock       in     1       system clock (rising edge)
//   reset       in     1       synchronous, active-high
//   address     in     ADDR_W  burst start address (sampled in IDLE)
//   data        inout  DATA_W  shared bus, driven only on read beats
//   MEMbus      in     1       read request (with we=0)
//   BUSmem      in     1       write request (with we=1)
//   we          in     1       direction qualifier
//   burst_len   in     BL_W    beats minus one (sampled in IDLE)
//   busy        out    1       controller not in IDLE
//   ack         out    1       a beat transfers this cycle
//   parity_err  out    1       read-beat parity fault (0 without the macro)
// -----------------------------------------------------------------------------
module smp_burst_memory
    import smp_mem_pkg::*;
#(
    parameter int    DATA_W    = DEF_DATA_W,
    parameter int    ADDR_W    = DEF_ADDR_W,
    parameter int    RD_LAT    = 1,
    parameter int    BL_W      = DEF_BL_W,
    parameter string INIT_FILE = "mem.mif"
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data,
    input  logic              MEMbus,
    input  logic              BUSmem,
    input  logic              we,
    input  logic [BL_W-1:0]   burst_len,
    output logic              busy,
    output logic              ack,
    output logic              parity_err
);

`ifdef SMP_MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    // RD_WAIT lasts RD_LAT-1 cycles; the counter is loaded with that count
    // minus one so that lat_q==0 marks the last wait cycle.
    localparam logic [2:0] LAT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [BL_W-1:0]   cnt_q, cnt_d;
    logic [2:0]        lat_q, lat_d;

    logic              start_wr, start_rd;
    logic              rd_beat, wr_beat;
    logic              drive_en, ram_wr_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [WORD_W-1:0] ram_wr_word;
    logic [WORD_W-1:0] ram_rd_word;

    assign start_wr = BUSmem && we;
    assign start_rd = MEMbus && !we;

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    // ---------------------------------------------------------------- next state
    // A dropped request line in any busy state aborts the burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_wr) begin
                    state_d = WR_BEAT;
                end else if (start_rd) begin
                    state_d = (RD_LAT == 1) ? RD_BEAT : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!MEMbus) begin
                    state_d = IDLE;
                end else if (lat_q == 3'd0) begin
                    state_d = RD_BEAT;
                end
            end
            RD_BEAT: begin
                if (!MEMbus || cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            WR_BEAT: begin
                if (!BUSmem || cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer / beat / latency counters. ptr_q always holds the address of
    // the beat currently in flight.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        lat_d = lat_q;
        case (state_q)
            IDLE: begin
                if (start_wr || start_rd) begin
                    ptr_d = address;
                    cnt_d = burst_len;
                    lat_d = LAT_INIT;
                end
            end
            RD_WAIT: begin
                if (lat_q != 3'd0) begin
                    lat_d = lat_q - 3'd1;
                end
            end
            RD_BEAT, WR_BEAT: begin
                if (rd_beat || wr_beat) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    cnt_d = cnt_q - BL_W'(1);
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy      = (state_q != IDLE);
        rd_beat   = (state_q == RD_BEAT) && MEMbus;
        wr_beat   = (state_q == WR_BEAT) && BUSmem;
        ack       = rd_beat || wr_beat;
        // Never drive the bus while the master claims it with we=1.
        drive_en  = rd_beat && !we;
        ram_wr_en = wr_beat && !reset;
`ifdef SMP_MEM_PARITY_EN
        parity_err = rd_beat &&
                     (ram_rd_word[DATA_W] !=
                      even_parity(PAR_MAX_W'(ram_rd_word[DATA_W-1:0])));
`else
        parity_err = 1'b0;
`endif
    end

    // Read address selects the word needed at the next edge: the start
    // address while idle (so RD_LAT=1 can beat right after the request), the
    // current pointer while waiting, and the following word during beats.
    always_comb begin
        case (state_q)
            IDLE:    ram_rd_addr = address;
            RD_BEAT: ram_rd_addr = ptr_q + ADDR_W'(1);
            default: ram_rd_addr = ptr_q;
        endcase
    end

`ifdef SMP_MEM_PARITY_EN
    assign ram_wr_word = {even_parity(PAR_MAX_W'(data)), data};
`else
    assign ram_wr_word = data;
`endif

    assign data = drive_en ? ram_rd_word[DATA_W-1:0] : 'z;

    smp_ram_array #(
        .WORD_W    (WORD_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk       (clock),
        .wr_en     (ram_wr_en),
        .wr_addr   (ptr_q),
        .wr_word   (ram_wr_word),
        .rd_addr   (ram_rd_addr),
        .rd_word_q (ram_rd_word)
    );

endmodule
